// File: rtl/prv664_wb_pkg.sv
// Shared constants for the PRV664 writeback scheduler: source ordering and
// default aging parameters.
package prv664_wb_pkg;

    localparam int WB_NREQ = 8;

    // Writeback source slots. This order is also the aged-source priority.
    localparam int WB_IDX_LSU    = 0;
    localparam int WB_IDX_ALU0   = 1;
    localparam int WB_IDX_ALU1   = 2;
    localparam int WB_IDX_MDIV   = 3;
    localparam int WB_IDX_FPU    = 4;
    localparam int WB_IDX_BRU    = 5;
    localparam int WB_IDX_BYPASS = 6;
    localparam int WB_IDX_SYSMAG = 7;

    localparam int WB_AGE_W   = 4;
    localparam int WB_AGE_MAX = 12;

    function automatic int wb_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/prv664_rr_pick.sv
// Rotating-priority picker: aged requesters win by lowest index, otherwise the
// first eligible requester at or after ptr_i (with wrap) is chosen.
module prv664_rr_pick #(
    parameter int NREQ = 8
) (
    input  logic [NREQ-1:0]         elig_i,
    input  logic [NREQ-1:0]         aged_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         onehot_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]  urgent;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        urgent = elig_i & aged_i;
        pick   = '0;
        cand   = '0;
        found  = 1'b0;
        if (|urgent) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && urgent[i]) begin
                    found = 1'b1;
                    pick  = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = IDX_W'((int'(ptr_i) + k) % NREQ);
                if (!found && elig_i[cand]) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
        end
        any_o    = |elig_i;
        idx_o    = pick;
        onehot_o = '0;
        if (found) begin
            onehot_o[pick] = 1'b1;
        end
    end

endmodule

// File: rtl/prv664_wb_sched.sv
// Two-bank writeback scheduler: round-robin grant per ROB bank with per-source
// starvation aging that lets long-waiting sources preempt the rotation.
module prv664_wb_sched
    import prv664_wb_pkg::*;
#(
    parameter int NREQ    = WB_NREQ,
    parameter int AGE_W   = WB_AGE_W,
    parameter int AGE_MAX = WB_AGE_MAX
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      flush_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ-1:0]           req_bank_i,
    input  logic [1:0]                bank_ready_i,
    output logic [1:0]                bank_valid_o,
    output logic [2*NREQ-1:0]         bank_sel_o,
    output logic [2*$clog2(NREQ)-1:0] bank_idx_o,
    output logic [NREQ-1:0]           req_ready_o,
    output logic [NREQ-1:0]           starve_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [AGE_W-1:0] AGE_SAT = '1;
    localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_MAX);

    logic                       run_q, run_d;
    logic [1:0][IDX_W-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0][AGE_W-1:0] age_q, age_d;

    logic [1:0][NREQ-1:0]  elig;
    logic [1:0][NREQ-1:0]  sel;
    logic [1:0][IDX_W-1:0] idx;
    logic [1:0]            any;
    logic [1:0]            hs;
    logic [NREQ-1:0]       aged;

    // run gates everything so the cycle right after reset release is idle
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            aged[i] = (age_q[i] >= AGE_THR);
        end
        elig[0] = req_valid_i & ~req_bank_i & {NREQ{run_q}};
        elig[1] = req_valid_i &  req_bank_i & {NREQ{run_q}};
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        prv664_rr_pick #(
            .NREQ(NREQ)
        ) u_pick (
            .elig_i  (elig[b]),
            .aged_i  (aged),
            .ptr_i   (ptr_q[b]),
            .onehot_o(sel[b]),
            .idx_o   (idx[b]),
            .any_o   (any[b])
        );
    end

    // bank_ready_i only reaches req_ready_o and the state update
    always_comb begin
        hs          = any & bank_ready_i;
        req_ready_o = (sel[0] & {NREQ{bank_ready_i[0]}})
                    | (sel[1] & {NREQ{bank_ready_i[1]}});
    end

    assign bank_valid_o = any;
    assign bank_sel_o   = sel;
    assign bank_idx_o   = idx;
    assign starve_o     = aged;

    always_comb begin
        run_d = 1'b1;
        ptr_d = ptr_q;
        age_d = age_q;
        for (int b = 0; b < 2; b++) begin
            if (flush_i) begin
                ptr_d[b] = '0;
            end else if (hs[b]) begin
                ptr_d[b] = IDX_W'(wb_wrap_inc(int'(idx[b]), NREQ));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (flush_i || !req_valid_i[i] || req_ready_o[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_SAT) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            run_q <= 1'b0;
            ptr_q <= '0;
            age_q <= '0;
        end else begin
            run_q <= run_d;
            ptr_q <= ptr_d;
            age_q <= age_d;
        end
    end

endmodule
